// File: rtl/axis_packet_arbiter_if.sv
// rtl/axis_packet_arbiter_if.sv - stream bundle between NUM_SRC sources and the shared arbiter output
interface axis_packet_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2,
    parameter int DEST_WIDTH = 2
);
    // Source side: per-source lanes packed side by side, source i at lane i
    logic [NUM_SRC*DATA_WIDTH-1:0] S_TDATA;
    logic [NUM_SRC-1:0]            S_TLAST;
    logic [NUM_SRC*DEST_WIDTH-1:0] S_TDEST;
    logic [NUM_SRC-1:0]            S_TVALID;
    logic [NUM_SRC-1:0]            S_TREADY;

    // Shared output stream
    logic [DATA_WIDTH-1:0]         M_TDATA;
    logic                          M_TLAST;
    logic [ID_WIDTH-1:0]           M_TID;
    logic [DEST_WIDTH-1:0]         M_TDEST;
    logic                          M_TVALID;
    logic                          M_TREADY;

    // Arbiter view: it masters the output stream and answers the sources
    modport master (
        input  S_TDATA, S_TLAST, S_TDEST, S_TVALID, M_TREADY,
        output S_TREADY, M_TDATA, M_TLAST, M_TID, M_TDEST, M_TVALID
    );

    // Environment view: sources plus the downstream sink
    modport slave (
        output S_TDATA, S_TLAST, S_TDEST, S_TVALID, M_TREADY,
        input  S_TREADY, M_TDATA, M_TLAST, M_TID, M_TDEST, M_TVALID
    );
endinterface

// File: rtl/axis_packet_arbiter.sv
// rtl/axis_packet_arbiter.sv - packet-granular round-robin AXI4-Stream arbiter; AXIS_ARB_PRIO0_EN gives source 0 strict priority
module axis_packet_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2,
    parameter int DEST_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    axis_packet_arbiter_if.master bus,
    output logic                  busy,
    output logic [31:0]           pkt_count
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW    = IDX_W + 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_gnt;
    logic [IDX_W-1:0]    w_gnt_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [31:0]         r_pkt_count;
    logic [31:0]         w_pkt_count_nxt;

    logic                w_req_found;
    logic [IDX_W-1:0]    w_req_idx;
    logic [IDX_W-1:0]    w_gnt_inc;
    logic                w_busy;

    logic [DATA_WIDTH-1:0] w_m_tdata;
    logic                  w_m_tlast;
    logic [DEST_WIDTH-1:0] w_m_tdest;
    logic                  w_m_tvalid;
    logic [ID_WIDTH-1:0]   w_m_tid;
    logic [NUM_SRC-1:0]    w_s_tready;

    // Pick the first requester at or after ptr, wrapping mod NUM_SRC
    always_comb begin
        logic [CW-1:0] v_cand;
        w_req_found = 1'b0;
        w_req_idx   = '0;
        v_cand      = '0;
        // Walk from the farthest candidate back to ptr so the nearest one wins
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            v_cand = {1'b0, r_ptr} + CW'(k);
            if (v_cand >= CW'(NUM_SRC)) begin
                v_cand = v_cand - CW'(NUM_SRC);
            end
            if (bus.S_TVALID[v_cand[IDX_W-1:0]]) begin
                w_req_found = 1'b1;
                w_req_idx   = v_cand[IDX_W-1:0];
            end
        end
`ifdef AXIS_ARB_PRIO0_EN
        // Source 0 overrides the rotation whenever it is requesting
        if (bus.S_TVALID[0]) begin
            w_req_found = 1'b1;
            w_req_idx   = '0;
        end
`endif
    end

    // Successor of the current grant, used as the next starting point
    always_comb begin
        w_gnt_inc = '0;
        if (r_gnt != IDX_W'(NUM_SRC - 1)) begin
            w_gnt_inc = r_gnt + 1'b1;
        end
    end

    // Zero-latency output mux; everything is quiet while idle
    always_comb begin
        w_m_tdata  = '0;
        w_m_tlast  = 1'b0;
        w_m_tdest  = '0;
        w_m_tvalid = 1'b0;
        w_m_tid    = '0;
        w_s_tready = '0;
        if (r_state == ST_GRANTED) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (r_gnt == IDX_W'(i)) begin
                    w_m_tdata     = bus.S_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
                    w_m_tlast     = bus.S_TLAST[i];
                    w_m_tdest     = bus.S_TDEST[i*DEST_WIDTH +: DEST_WIDTH];
                    w_m_tvalid    = bus.S_TVALID[i];
                    w_s_tready[i] = bus.M_TREADY;
                end
            end
            w_m_tid = ID_WIDTH'(r_gnt);
        end
    end

    // Next state: arbitrate in IDLE, hold the grant until TLAST is accepted
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_ptr_nxt       = r_ptr;
        w_pkt_count_nxt = r_pkt_count;
        w_busy          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_req_found) begin
                    w_state_nxt = ST_GRANTED;
                    w_gnt_nxt   = w_req_idx;
                end
            end
            ST_GRANTED: begin
                w_busy = 1'b1;
                if (w_m_tvalid && bus.M_TREADY && w_m_tlast) begin
                    w_state_nxt     = ST_IDLE;
                    w_ptr_nxt       = w_gnt_inc;
                    w_pkt_count_nxt = r_pkt_count + 32'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, grant, pointer and packet counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_ptr       <= '0;
            r_pkt_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_pkt_count <= w_pkt_count_nxt;
        end
    end

    assign bus.M_TDATA  = w_m_tdata;
    assign bus.M_TLAST  = w_m_tlast;
    assign bus.M_TDEST  = w_m_tdest;
    assign bus.M_TVALID = w_m_tvalid;
    assign bus.M_TID    = w_m_tid;
    assign bus.S_TREADY = w_s_tready;
    assign busy         = w_busy;
    assign pkt_count    = r_pkt_count;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb/tb_axis_packet_arbiter.sv - randomized self-checking bench for axis_packet_arbiter
`timescale 1ns/1ps
module tb_axis_packet_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int IW  = 2;
    localparam int DSW = 2;
    localparam int BW  = DW + DSW + 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        busy;
    logic [31:0] pkt_count;

    axis_packet_arbiter_if #(.NUM_SRC(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW)) bus ();

    axis_packet_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .bus       (bus),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clock = ~clock;

    int n_vec;
    int n_err;

    // Per-source beat queues: {tlast, tdest, tdata}
    logic [BW-1:0] srcq[N][$];
    int            valid_pct;
    int            ready_pct;
    bit            drv_en;

    // Reference model: arbiter described by its rules, not its circuit
    bit            m_busy;
    int            m_gnt;
    int            m_ptr;
    logic [31:0]   m_cnt;

    // Observed output stream
    int            act_order[$];
    logic [DW-1:0] act_data[$];
    bit            a_sop;

    function automatic int model_pick(input bit req[N], input int ptr);
        int r;
        r = -1;
`ifdef AXIS_ARB_PRIO0_EN
        if (req[0]) r = 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (r < 0 && req[(ptr + k) % N]) r = (ptr + k) % N;
        end
        return r;
    endfunction

    task automatic step(input int rdy, input bit rst);
        bit            sv[N];
        logic [BW-1:0] bt[N];
        logic [BW-1:0] gb;
        logic [N-1:0]  exp_tready;
        logic [IW-1:0] exp_tid;
        bit            exp_valid;
        bit            r;
        bit            hs;
        int            g;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            sv[i] = (srcq[i].size() > 0) && ($urandom_range(99) < valid_pct);
            bt[i] = (srcq[i].size() > 0) ? srcq[i][0] : BW'({$urandom, $urandom});
            bus.S_TDATA[i*DW +: DW]   = bt[i][DW-1:0];
            bus.S_TDEST[i*DSW +: DSW] = bt[i][DW +: DSW];
            bus.S_TLAST[i]            = bt[i][BW-1];
            bus.S_TVALID[i]           = sv[i];
        end
        r = (rdy < 0) ? ($urandom_range(99) < ready_pct) : (rdy != 0);
        bus.M_TREADY = r;
        reset        = rst;
        enable       = drv_en;
        #1;
        gb         = m_busy ? bt[m_gnt] : '0;
        exp_valid  = m_busy && sv[m_gnt];
        exp_tready = m_busy ? (N'(r) << m_gnt) : '0;
        exp_tid    = m_busy ? IW'(m_gnt) : '0;

        n_vec++;
        if (busy !== m_busy) begin
            n_err++; $display("FAIL busy: got %b want %b at %0t", busy, m_busy, $time);
        end
        n_vec++;
        if (bus.M_TVALID !== exp_valid) begin
            n_err++; $display("FAIL m_tvalid: got %b want %b at %0t", bus.M_TVALID, exp_valid, $time);
        end
        n_vec++;
        if (bus.S_TREADY !== exp_tready) begin
            n_err++; $display("FAIL s_tready: got %b want %b at %0t", bus.S_TREADY, exp_tready, $time);
        end
        n_vec++;
        if (pkt_count !== m_cnt) begin
            n_err++; $display("FAIL pkt_count: got %0d want %0d at %0t", pkt_count, m_cnt, $time);
        end
        n_vec++;
        if (bus.M_TID !== exp_tid) begin
            n_err++; $display("FAIL m_tid: got %0d want %0d at %0t", bus.M_TID, exp_tid, $time);
        end
        n_vec++;
        if (bus.M_TDATA !== gb[DW-1:0]) begin
            n_err++; $display("FAIL m_tdata: got %h want %h at %0t", bus.M_TDATA, gb[DW-1:0], $time);
        end
        n_vec++;
        if ({bus.M_TLAST, bus.M_TDEST} !== gb[BW-1:DW]) begin
            n_err++; $display("FAIL m_tlast_tdest: got %b want %b at %0t", {bus.M_TLAST, bus.M_TDEST}, gb[BW-1:DW], $time);
        end

        if (bus.M_TVALID === 1'b1 && bus.M_TREADY === 1'b1) begin
            if (a_sop) act_order.push_back(int'(bus.M_TID));
            act_data.push_back(bus.M_TDATA);
            a_sop = bus.M_TLAST;
        end
        if (rst) a_sop = 1'b1;

        hs = m_busy && sv[m_gnt] && r;
        if (hs) void'(srcq[m_gnt].pop_front());
        if (rst) begin
            m_busy = 1'b0; m_gnt = 0; m_ptr = 0; m_cnt = '0;
        end else if (!m_busy) begin
            if (drv_en) begin
                g = model_pick(sv, m_ptr);
                if (g >= 0) begin
                    m_busy = 1'b1;
                    m_gnt  = g;
                end
            end
        end else if (hs && gb[BW-1]) begin
            m_busy = 1'b0;
            m_ptr  = (m_gnt + 1) % N;
            m_cnt  = m_cnt + 32'd1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) srcq[i].delete();
    endtask

    task automatic push_pkt(input int s, input int len, input int base);
        for (int b = 0; b < len; b++) begin
            srcq[s].push_back({(b == len - 1) ? 1'b1 : 1'b0, DSW'($urandom), DW'(base + b)});
        end
    endtask

    task automatic do_reset();
        flush();
        drv_en    = 1'b1;
        valid_pct = 100;
        ready_pct = 100;
        repeat (2) step(1, 1'b1);
        act_order.delete();
        act_data.delete();
        a_sop = 1'b1;
    endtask

    task automatic test_reset();
        flush();
        drv_en    = 1'b1;
        valid_pct = 100;
        for (int s = 0; s < N; s++) push_pkt(s, 5, s * 16);
        repeat (3) step(1, 1'b1);
        n_vec++;
        if (busy !== 1'b0 || bus.M_TVALID !== 1'b0) begin
            n_err++; $display("FAIL reset_idle: busy=%b tvalid=%b want 0/0", busy, bus.M_TVALID);
        end
        step(1, 1'b0);
        n_vec++;
        if (busy !== 1'b1 || bus.M_TID !== 2'd0) begin
            n_err++; $display("FAIL reset_first_grant: busy=%b tid=%0d want 1/0", busy, bus.M_TID);
        end
        n_vec++;
        if (pkt_count !== 32'd0) begin
            n_err++; $display("FAIL reset_count: got %0d want 0", pkt_count);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int s = 0; s < N; s++) push_pkt(s, 3, s * 16);
        repeat (15) step(1, 1'b0);
        n_vec++;
        if (pkt_count !== 32'd3) begin
            n_err++; $display("FAIL rr_count15: got %0d want 3", pkt_count);
        end
        step(1, 1'b0);
        n_vec++;
        if (pkt_count !== 32'd4) begin
            n_err++; $display("FAIL rr_count16: got %0d want 4", pkt_count);
        end
        n_vec++;
        if (act_order.size() != 4 || act_data.size() != 12) begin
            n_err++; $display("FAIL rr_sizes: got %0d pkts %0d beats want 4/12", act_order.size(), act_data.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (act_order[k] != k) begin
                    n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, act_order[k], k);
                end
            end
            for (int k = 0; k < 12; k++) begin
                n_vec++;
                if (act_data[k] !== DW'((k / 3) * 16 + (k % 3))) begin
                    n_err++; $display("FAIL rr_data[%0d]: got %h want %h", k, act_data[k], (k / 3) * 16 + (k % 3));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        push_pkt(1, 4, 'h100);
        step(1, 1'b0);
        step(1, 1'b0);
        push_pkt(2, 3, 'h200);
        for (int k = 0; k < 16; k++) step((k % 2 == 0) ? 1 : 0, 1'b0);
        n_vec++;
        if (pkt_count !== 32'd2) begin
            n_err++; $display("FAIL bp_count: got %0d want 2", pkt_count);
        end
        n_vec++;
        if (act_order.size() != 2 || act_order[0] != 1 || act_order[1] != 2) begin
            n_err++; $display("FAIL bp_order: got %0d pkts first %0d want 2 pkts 1,2", act_order.size(), (act_order.size() > 0) ? act_order[0] : -1);
        end
    endtask

    task automatic test_enable_gate();
        do_reset();
        push_pkt(0, 4, 'h300);
        step(1, 1'b0);
        step(1, 1'b0);
        drv_en = 1'b0;
        repeat (3) step(1, 1'b0);
        push_pkt(3, 2, 'h330);
        push_pkt(1, 2, 'h310);
        for (int k = 0; k < 4; k++) begin
            step(1, 1'b0);
            n_vec++;
            if (busy !== 1'b0) begin
                n_err++; $display("FAIL en_hold[%0d]: busy got %b want 0", k, busy);
            end
        end
        drv_en = 1'b1;
        step(1, 1'b0);
        n_vec++;
        if (busy !== 1'b1 || bus.M_TID !== 2'd1) begin
            n_err++; $display("FAIL en_resume: busy=%b tid=%0d want 1/1", busy, bus.M_TID);
        end
        repeat (7) step(1, 1'b0);
        n_vec++;
        if (pkt_count !== 32'd3) begin
            n_err++; $display("FAIL en_count: got %0d want 3", pkt_count);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        push_pkt(1, 1, 'h400);
        step(1, 1'b0);
        step(1, 1'b0);
        push_pkt(2, 4, 'h420);
        step(1, 1'b0);
        step(1, 1'b0);
        step(1, 1'b1);
        n_vec++;
        if (busy !== 1'b0 || bus.M_TVALID !== 1'b0 || pkt_count !== 32'd0) begin
            n_err++; $display("FAIL midrst: busy=%b tvalid=%b count=%0d want 0/0/0", busy, bus.M_TVALID, pkt_count);
        end
        flush();
        push_pkt(3, 1, 'h430);
        push_pkt(0, 1, 'h400);
        step(1, 1'b0);
        n_vec++;
        if (busy !== 1'b1 || bus.M_TID !== 2'd0) begin
            n_err++; $display("FAIL midrst_ptr: busy=%b tid=%0d want 1/0", busy, bus.M_TID);
        end
    endtask

    task automatic test_priority();
        int exp_o[4];
`ifdef AXIS_ARB_PRIO0_EN
        exp_o = '{0, 0, 0, 0};
`else
        exp_o = '{3, 0, 3, 0};
`endif
        do_reset();
        push_pkt(2, 1, 'h500);
        step(1, 1'b0);
        step(1, 1'b0);
        act_order.delete();
        for (int p = 0; p < 6; p++) begin
            push_pkt(0, 2, 'h600 + p * 4);
            push_pkt(3, 2, 'h700 + p * 4);
        end
        repeat (12) step(1, 1'b0);
        n_vec++;
        if (act_order.size() < 4) begin
            n_err++; $display("FAIL prio_pkts: got %0d want >=4", act_order.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (act_order[k] != exp_o[k]) begin
                    n_err++; $display("FAIL prio_order[%0d]: got %0d want %0d", k, act_order[k], exp_o[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        int  total;
        int  cyc;
        bit  done;
        do_reset();
        total = 0;
        for (int s = 0; s < N; s++) begin
            for (int p = 0; p < 6; p++) begin
                push_pkt(s, $urandom_range(1, 5), s * 4096 + p * 16);
                total++;
            end
        end
        valid_pct = 70;
        ready_pct = 60;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 3000) begin
            drv_en = ($urandom_range(9) != 0);
            step(-1, 1'b0);
            cyc++;
            done = !m_busy && srcq[0].size() == 0 && srcq[1].size() == 0 &&
                   srcq[2].size() == 0 && srcq[3].size() == 0;
        end
        n_vec++;
        if (!done) begin
            n_err++; $display("FAIL rand_timeout: drained %b want 1 after %0d cycles", done, cyc);
        end
        n_vec++;
        if (pkt_count !== 32'(total) || act_order.size() != total) begin
            n_err++; $display("FAIL rand_count: got %0d/%0d want %0d", pkt_count, act_order.size(), total);
        end
        drv_en    = 1'b1;
        valid_pct = 100;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        enable       = 1'b0;
        bus.S_TDATA  = '0;
        bus.S_TLAST  = '0;
        bus.S_TDEST  = '0;
        bus.S_TVALID = '0;
        bus.M_TREADY = 1'b0;
        m_busy       = 1'b0;
        m_gnt        = 0;
        m_ptr        = 0;
        m_cnt        = '0;
        a_sop        = 1'b1;
        valid_pct    = 100;
        ready_pct    = 100;
        drv_en       = 1'b1;

        test_reset();
        test_round_robin();
        test_backpressure();
        test_enable_gate();
        test_reset_mid_packet();
        test_priority();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
